// File: rtl/data_mem_unit.sv
// data_mem_unit: byte/half/word data memory with wait states, clear sweep and one IO register (optional DMEM_MISALIGN_ERR_EN)
module data_mem_unit #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] IO_ADDR     = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] in_data,
    input  logic [1:0]  mem_size,
    input  logic        sz_ex,
    output logic        ready,
    output logic        done,
    output logic [31:0] out_data,
    output logic [31:0] mem_map_io,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state;
    logic [AW-1:0]   clr_idx;
    logic [2:0]      cnt;
    logic            wr_q;
    logic            sx_q;
    logic [31:0]     addr_q;
    logic [31:0]     data_q;
    logic [1:0]      size_q;
    logic [31:0]     mem [DEPTH_WORDS];
    logic [AW-1:0]   idx;
    logic            io_sel;
    logic            mis;
    logic            bad;
    logic [1:0]      off;
    logic [3:0]      mask;
    logic [31:0]     cur;
    logic [31:0]     shifted;
    logic [31:0]     merged;
    logic [31:0]     rsh;
    logic [31:0]     load_val;
    logic            we;
    logic [AW-1:0]   widx;
    logic [31:0]     wdata;

`ifdef DMEM_MISALIGN_ERR_EN
    assign mis = (size_q == 2'b01 && addr_q[0]) || (size_q == 2'b10 && addr_q[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // decode the latched request, merge store lanes and extract/extend load data
    always_comb begin
        idx      = addr_q[AW+1:2];
        io_sel   = addr_q[31:2] == IO_ADDR[31:2];
        off      = size_q == 2'b00 ? addr_q[1:0] : size_q == 2'b01 ? {addr_q[1], 1'b0} : 2'b00;
        mask     = size_q == 2'b00 ? 4'b0001 << off : size_q == 2'b01 ? 4'b0011 << off : 4'b1111;
        cur      = io_sel ? mem_map_io : mem[idx];
        shifted  = data_q << {off, 3'b000};
        merged   = cur;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = mask[i] ? shifted[8*i +: 8] : cur[8*i +: 8];
        rsh      = cur >> {off, 3'b000};
        load_val = size_q == 2'b00 ? {{24{sx_q & rsh[7]}}, rsh[7:0]} :
                   size_q == 2'b01 ? {{16{sx_q & rsh[15]}}, rsh[15:0]} : cur;
        bad      = size_q == 2'b11 || mis;
        we       = !rst && (state == S_CLEAR || (state == S_RESP && wr_q && !bad && !io_sel));
        widx     = state == S_CLEAR ? clr_idx : idx;
        wdata    = state == S_CLEAR ? '0 : merged;
    end

    // single write port shared by the clearing sweep and stores
    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdata;
    end

    // control FSM with registered handshake, result and IO register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CLEAR;
            clr_idx    <= '0;
            ready      <= 1'b0;
            done       <= 1'b0;
            out_data   <= '0;
            mem_map_io <= '0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == AW'(DEPTH_WORDS - 1)) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req) begin
                        wr_q   <= wr_en;
                        addr_q <= address;
                        data_q <= in_data;
                        size_q <= mem_size;
                        sx_q   <= sz_ex;
                        ready  <= 1'b0;
                        cnt    <= '0;
                        state  <= WAIT_STATES > 0 ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == 3'(WAIT_STATES - 1)) state <= S_RESP;
                end
                S_RESP: begin
                    done  <= 1'b1;
                    err   <= bad;
                    ready <= 1'b1;
                    state <= S_IDLE;
                    if (bad) out_data <= '0;
                    else if (!wr_q) out_data <= load_val;
                    if (wr_q && !bad && io_sel) mem_map_io <= merged;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: directed vector table, reset/abort sequences and random accesses against a byte-level model
module tb_data_mem_unit;
    localparam int          DEPTH = 256;
    localparam int          WS    = 1;
    localparam logic [31:0] IO    = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr_en = 1'b0;
    logic        sz_ex = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] in_data = '0;
    logic [1:0]  mem_size = '0;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] out_data;
    logic [31:0] mem_map_io;

    int total = 0;
    int bad   = 0;

    logic [31:0] mw [DEPTH];
    logic [31:0] m_io;
    logic [31:0] m_out;
    logic        m_err;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        logic        sx;
        logic        c;
        logic [31:0] eo;
        logic        ee;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    data_mem_unit #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .IO_ADDR(IO)) dut (
        .clk(clk), .rst(rst), .req(req), .wr_en(wr_en), .address(address),
        .in_data(in_data), .mem_size(mem_size), .sz_ex(sz_ex), .ready(ready),
        .done(done), .out_data(out_data), .mem_map_io(mem_map_io), .err(err)
    );

    function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] d, logic [1:0] sz,
                                logic sx, logic c, logic [31:0] eo, logic ee);
        vec_t t;
        t.w = w; t.a = a; t.d = d; t.sz = sz; t.sx = sx; t.c = c; t.eo = eo; t.ee = ee;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset;
        for (int i = 0; i < DEPTH; i++) mw[i] = '0;
        m_io  = '0;
        m_out = '0;
    endtask

    task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic sx);
        int          nb;
        int          base;
        int          wi;
        logic        io;
        logic [31:0] ea;
        logic [31:0] word;
        logic [31:0] v;
        nb    = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        m_err = sz == 2'd3;
`ifdef DMEM_MISALIGN_ERR_EN
        if (sz == 2'd1 && a[0]) m_err = 1'b1;
        if (sz == 2'd2 && a[1:0] != 2'b00) m_err = 1'b1;
`endif
        if (m_err) begin
            m_out = '0;
            return;
        end
        ea = a;
        if (sz == 2'd1) ea[0] = 1'b0;
        if (sz == 2'd2) ea[1:0] = 2'b00;
        io   = (a >> 2) == (IO >> 2);
        wi   = int'((a >> 2) % DEPTH);
        word = io ? m_io : mw[wi];
        base = int'(ea[1:0]);
        if (w) begin
            for (int i = 0; i < nb; i++) word[8*(base+i) +: 8] = d[8*i +: 8];
            if (io) m_io = word;
            else mw[wi] = word;
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = word[8*(base+i) +: 8];
            if (sx && nb < 4 && v[8*nb-1])
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            m_out = v;
        end
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic sx, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk({name, " ready"}, {31'b0, ready}, 32'd1);
        req = 1'b1; wr_en = w; address = a; in_data = d; mem_size = sz; sz_ex = sx;
        @(posedge clk);
        #1 req = 1'b0;
        model(w, a, d, sz, sx);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!done && n < 40);
        chk({name, " latency"}, 32'(n), 32'(1 + WS));
        chk({name, " err"}, {31'b0, err}, {31'b0, m_err});
        chk({name, " out_data"}, out_data, m_out);
        chk({name, " mem_map_io"}, mem_map_io, m_io);
        chk({name, " ready_after"}, {31'b0, ready}, 32'd1);
    endtask

    task automatic do_reset;
        int n;
        @(negedge clk);
        rst = 1'b1;
        req = 1'b1; wr_en = 1'b1; address = 32'h40; in_data = 32'hDEAD_BEEF; mem_size = 2'd2; sz_ex = 1'b0;
        @(posedge clk);
        #1;
        chk("rst ready", {31'b0, ready}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst err", {31'b0, err}, 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst mem_map_io", mem_map_io, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!ready && n < 5000);
        req = 1'b0;
        chk("clear cycles", 32'(n), 32'(DEPTH));
        model_reset;
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;

        do_reset;
        access(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, "t1 load");
        chk("t1 value", out_data, 32'h0);

        tbl.push_back(mk(1, 32'h0,   32'hFF00FF00, 2'd2, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        2'd2, 0, 1, 32'hFF00FF00, 0));
        tbl.push_back(mk(0, 32'h1,   32'h0,        2'd0, 1, 1, 32'hFFFFFFFF, 0));
        tbl.push_back(mk(0, 32'h1,   32'h0,        2'd0, 0, 1, 32'h000000FF, 0));
        tbl.push_back(mk(0, 32'h2,   32'h0,        2'd1, 1, 1, 32'hFFFFFF00, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        2'd1, 0, 1, 32'h0000FF00, 0));
        tbl.push_back(mk(1, 32'd128, 32'h11223344, 2'd2, 0, 0, 32'h0,        0));
        tbl.push_back(mk(1, 32'd130, 32'h00FF00FF, 2'd1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 32'd128, 32'h0,        2'd2, 0, 1, 32'h00FF3344, 0));
        tbl.push_back(mk(0, 32'd128 + 32'(4*DEPTH), 32'h0, 2'd2, 0, 1, 32'h00FF3344, 0));
        tbl.push_back(mk(1, IO + 32'd3, 32'h000000A5, 2'd0, 0, 0, 32'h0,     0));
        tbl.push_back(mk(0, IO,      32'h0,        2'd2, 0, 1, 32'hA5000000, 0));
`ifdef DMEM_MISALIGN_ERR_EN
        tbl.push_back(mk(1, 32'h83,  32'h0000BEEF, 2'd1, 0, 1, 32'h0,        1));
        tbl.push_back(mk(0, 32'h80,  32'h0,        2'd2, 0, 1, 32'h00FF3344, 0));
`else
        tbl.push_back(mk(1, 32'h83,  32'h0000BEEF, 2'd1, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 32'h82,  32'h0,        2'd1, 0, 1, 32'h0000BEEF, 0));
`endif
        tbl.push_back(mk(0, 32'h0,   32'h0,        2'd3, 0, 1, 32'h0,        1));
        tbl.push_back(mk(1, 32'h0,   32'h12345678, 2'd3, 0, 1, 32'h0,        1));
        tbl.push_back(mk(0, 32'h0,   32'h0,        2'd2, 0, 1, 32'hFF00FF00, 0));

        foreach (tbl[i]) begin
            access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].sz, tbl[i].sx, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl_err", i), {31'b0, err}, {31'b0, tbl[i].ee});
            if (tbl[i].c) chk($sformatf("vec%0d tbl_out", i), out_data, tbl[i].eo);
            if (tbl[i].w && tbl[i].a == IO + 32'd3) begin
                @(posedge clk);
                #1 chk("t5 mem_map_io", mem_map_io, 32'hA5000000);
            end
        end

        for (int k = 0; k < 300; k++) begin
            r  = $urandom_range(0, 3);
            a  = r == 0 ? 32'($urandom_range(0, 63)) :
                 r == 1 ? IO + 32'($urandom_range(0, 3)) :
                 r == 2 ? 32'($urandom) :
                          32'($urandom_range(0, 63)) + 32'(4 * DEPTH) * 32'($urandom_range(1, 5));
            r  = $urandom_range(0, 9);
            sz = r == 9 ? 2'd3 : 2'(r % 3);
            access(1'($urandom_range(0, 1)), a, 32'($urandom), sz, 1'($urandom_range(0, 1)),
                   $sformatf("rnd%0d", k));
        end

        access(1'b1, 32'h40, 32'hCAFEF00D, 2'd2, 1'b0, "pre-abort store");
        access(1'b1, IO, 32'h5A5A5A5A, 2'd2, 1'b0, "pre-abort io");
        @(negedge clk);
        req = 1'b1; wr_en = 1'b1; address = 32'h44; in_data = 32'h87654321; mem_size = 2'd2; sz_ex = 1'b0;
        @(posedge clk);
        #1 req = 1'b0;
        do_reset;
        access(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, "post-abort @40");
        chk("post-abort cleared", out_data, 32'h0);
        access(1'b0, 32'h44, 32'h0, 2'd2, 1'b0, "post-abort @44");
        chk("aborted store", out_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
